clus_pattern_check: RTL and testbench

CLUS_PATTERN_CHECK -- requirements
Module: clus_pattern_check

---
 rtl/clus_pattern_check_if.sv | 11 +
 rtl/clus_pattern_check.sv | 143 ++++++++++++++
 tb/tb_clus_pattern_check.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clus_pattern_check_if.sv
// FIFO read-side bundle between the pattern checker (master) and its source FIFO (slave).
interface clus_pattern_check_if #(
    parameter int DATA_W = 32
) ();
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_re;

    modport master (input fifo_empty, input fifo_data, output fifo_re);
    modport slave  (output fifo_empty, output fifo_data, input fifo_re);
endinterface

// File: rtl/clus_pattern_check.sv
// Reads tagged events from a FIFO and checks header tag continuity and payload
// pattern (incrementing counter or alternating 0x55/0xAA), keeping sticky flags and counts.
module clus_pattern_check #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 20
) (
    input  logic                        fifoclk,
    input  logic                        fifoclk_reset,
    input  logic                        check_enable,
    input  logic                        pattern_type,
    input  logic                        err_clear,
    clus_pattern_check_if.master        fifo,
    output logic                        event_done,
    output logic [15:0]                 event_cnt,
    output logic [15:0]                 err_cnt,
    output logic                        tag_err,
    output logic                        data_err,
    output logic [TAG_W-1:0]            last_tag
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] HDR_RD  = 3'd1;
    localparam logic [2:0] HDR_CHK = 3'd2;
    localparam logic [2:0] DAT_RD  = 3'd3;
    localparam logic [2:0] DAT_CHK = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    localparam int SIZE_LSB = 20;
    localparam logic [DATA_W-1:0] PAT_55 = {(DATA_W/2){2'b01}};
    localparam logic [DATA_W-1:0] PAT_AA = ~PAT_55;

    logic [2:0]        state;
    logic [DATA_W-1:0] hdr;
    logic [DATA_W-1:0] exp_cnt;
    logic [DATA_W-1:0] exp_word;
    logic [13:0]       remaining;
    logic [TAG_W-1:0]  exp_tag;
    logic [TAG_W-1:0]  hdr_tag;
    logic [11:0]       hdr_size;
    logic              first_hdr;
    logic              exp_alt;
    logic              mode_alt;
    logic              zero_evt;
    logic              tag_mismatch;
    logic              data_mismatch;

    assign hdr_tag  = hdr[TAG_W-1:0];
    assign hdr_size = hdr[SIZE_LSB +: 12];
    assign exp_word = mode_alt ? (exp_alt ? PAT_AA : PAT_55) : exp_cnt;

    // Read strobe is decoded combinationally so it can only ever appear in IDLE/DAT_RD.
    assign fifo.fifo_re = !fifoclk_reset && !fifo.fifo_empty &&
                          (((state == IDLE) && check_enable) || (state == DAT_RD));

    assign event_done    = (state == DONE);
    assign tag_mismatch  = (state == HDR_CHK) && !first_hdr && (hdr_tag != exp_tag);
    assign data_mismatch = (state == DAT_CHK) && (fifo.fifo_data != exp_word);

    always_ff @(posedge fifoclk) begin
        if (fifoclk_reset) begin
            state     <= IDLE;
            hdr       <= '0;
            exp_cnt   <= '0;
            exp_alt   <= 1'b0;
            exp_tag   <= '0;
            remaining <= '0;
            first_hdr <= 1'b1;
            mode_alt  <= 1'b0;
            zero_evt  <= 1'b0;
            event_cnt <= '0;
            err_cnt   <= '0;
            tag_err   <= 1'b0;
            data_err  <= 1'b0;
            last_tag  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (check_enable && !fifo.fifo_empty)
                        state <= HDR_RD;
                end
                HDR_RD: begin
                    hdr   <= fifo.fifo_data;
                    state <= HDR_CHK;
                end
                HDR_CHK: begin
                    remaining <= {hdr_size, 2'b00};
                    last_tag  <= hdr_tag;
                    mode_alt  <= pattern_type;
                    zero_evt  <= (hdr_size == '0);
                    first_hdr <= 1'b0;
                    exp_tag   <= hdr_tag + 1'b1;
                    if (tag_mismatch)
                        tag_err <= 1'b1;
                    state <= (hdr_size == '0) ? DONE : DAT_RD;
                end
                DAT_RD: begin
                    if (!fifo.fifo_empty)
                        state <= DAT_CHK;
                end
                DAT_CHK: begin
                    remaining <= remaining - 1'b1;
                    if (data_mismatch) begin
                        // Resync to the received word so one bad word costs one error.
                        data_err <= 1'b1;
                        if (mode_alt)
                            exp_alt <= (fifo.fifo_data != PAT_AA);
                        else
                            exp_cnt <= fifo.fifo_data + 1'b1;
                    end else if (mode_alt) begin
                        exp_alt <= ~exp_alt;
                    end else begin
                        exp_cnt <= exp_cnt + 1'b1;
                    end
                    state <= (remaining == 14'd1) ? DONE : DAT_RD;
                end
                DONE: begin
                    event_cnt <= event_cnt + 1'b1;
                    if (zero_evt) begin
                        if (mode_alt)
                            exp_alt <= ~exp_alt;
                        else
                            exp_cnt <= exp_cnt + 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if ((tag_mismatch || data_mismatch) && (err_cnt != '1))
                err_cnt <= err_cnt + 1'b1;

            // Placed last so a clear beats any error or event count in the same cycle.
            if (err_clear) begin
                err_cnt   <= '0;
                event_cnt <= '0;
                tag_err   <= 1'b0;
                data_err  <= 1'b0;
                first_hdr <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clus_pattern_check.sv
// Directed bench for clus_pattern_check with a behavioural source FIFO.
module tb_clus_pattern_check;

    logic        fifoclk;
    logic        fifoclk_reset;
    logic        check_enable;
    logic        pattern_type;
    logic        err_clear;
    logic        event_done;
    logic [15:0] event_cnt;
    logic [15:0] err_cnt;
    logic        tag_err;
    logic        data_err;
    logic [19:0] last_tag;

    clus_pattern_check_if #(.DATA_W(32)) ifc ();

    clus_pattern_check #(.DATA_W(32), .TAG_W(20)) dut (
        .fifoclk       (fifoclk),
        .fifoclk_reset (fifoclk_reset),
        .check_enable  (check_enable),
        .pattern_type  (pattern_type),
        .err_clear     (err_clear),
        .fifo          (ifc),
        .event_done    (event_done),
        .event_cnt     (event_cnt),
        .err_cnt       (err_cnt),
        .tag_err       (tag_err),
        .data_err      (data_err),
        .last_tag      (last_tag)
    );

    initial fifoclk = 1'b0;
    always #5 fifoclk = ~fifoclk;

    logic [31:0] mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    bit flush  = 1'b0;
    int done_cnt = 0;
    int re_viol  = 0;
    int n_checks = 0;
    int n_pass   = 0;

    assign ifc.fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge fifoclk) begin
        if (flush) begin
            rd_ptr <= wr_ptr;
        end else if (ifc.fifo_re) begin
            ifc.fifo_data <= mem[rd_ptr[7:0]];
            rd_ptr        <= rd_ptr + 1;
        end
    end

    always @(negedge fifoclk) begin
        if (ifc.fifo_re && ifc.fifo_empty) re_viol++;
        if (event_done) done_cnt++;
    end

    task automatic step();
        @(posedge fifoclk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        mem[wr_ptr[7:0]] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    function automatic logic [31:0] hdr(input int tag, input int sz);
        logic [31:0] t;
        logic [31:0] s;
        t = tag;
        s = sz;
        return {s[11:0], t[19:0]};
    endfunction

    task automatic do_reset();
        fifoclk_reset = 1'b1;
        flush         = 1'b1;
        check_enable  = 1'b0;
        err_clear     = 1'b0;
        step();
        step();
        fifoclk_reset = 1'b0;
        flush         = 1'b0;
        step();
    endtask

    task automatic wait_events(input int target, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (done_cnt >= target) break;
            step();
        end
        n_checks++;
        if (done_cnt < target)
            $display("FAIL %s_timeout: events seen %0d, required %0d", name, done_cnt, target);
        else
            n_pass++;
    endtask

    task automatic test_reset();
        fifoclk_reset = 1'b1;
        flush = 1'b1;
        check_enable = 1'b0;
        pattern_type = 1'b0;
        err_clear = 1'b0;
        step(); step();
        fifoclk_reset = 1'b0;
        flush = 1'b0;
        n_checks++; if (event_cnt !== 16'd0) $display("FAIL reset_event_cnt: got %0d want 0", event_cnt); else n_pass++;
        n_checks++; if (err_cnt !== 16'd0) $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); else n_pass++;
        n_checks++; if ({tag_err, data_err, event_done} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {tag_err, data_err, event_done}); else n_pass++;
        n_checks++; if (last_tag !== 20'd0) $display("FAIL reset_last_tag: got %0d want 0", last_tag); else n_pass++;
        n_checks++; if (ifc.fifo_re !== 1'b0) $display("FAIL reset_fifo_re: got %b want 0", ifc.fifo_re); else n_pass++;
    endtask

    task automatic test_counter();
        int base;
        do_reset();
        pattern_type = 1'b0;
        push(hdr(5, 2));
        for (int i = 0; i < 8; i++) push(i);
        push(hdr(6, 1));
        for (int i = 8; i < 12; i++) push(i);
        base = done_cnt;
        check_enable = 1'b1;
        wait_events(base + 2, 200, "counter");
        n_checks++; if (event_cnt !== 16'd2) $display("FAIL counter_event_cnt: got %0d want 2", event_cnt); else n_pass++;
        n_checks++; if (err_cnt !== 16'd0) $display("FAIL counter_err_cnt: got %0d want 0", err_cnt); else n_pass++;
        n_checks++; if (last_tag !== 20'd6) $display("FAIL counter_last_tag: got %0d want 6", last_tag); else n_pass++;
        n_checks++; if ({tag_err, data_err} !== 2'b00) $display("FAIL counter_flags: got %b want 00", {tag_err, data_err}); else n_pass++;
    endtask

    task automatic test_size_zero();
        int base;
        do_reset();
        pattern_type = 1'b0;
        push(hdr(3, 0));
        push(hdr(4, 1));
        for (int i = 1; i <= 4; i++) push(i);
        base = done_cnt;
        check_enable = 1'b1;
        wait_events(base + 2, 200, "size_zero");
        n_checks++; if (err_cnt !== 16'd0) $display("FAIL size_zero_err_cnt: got %0d want 0", err_cnt); else n_pass++;
        n_checks++; if ({tag_err, data_err} !== 2'b00) $display("FAIL size_zero_flags: got %b want 00", {tag_err, data_err}); else n_pass++;
        n_checks++; if (event_cnt !== 16'd2) $display("FAIL size_zero_event_cnt: got %0d want 2", event_cnt); else n_pass++;
    endtask

    task automatic test_tag_seq();
        int base;
        do_reset();
        push(hdr(1, 0)); push(hdr(2, 0)); push(hdr(4, 0)); push(hdr(5, 0));
        base = done_cnt;
        check_enable = 1'b1;
        wait_events(base + 4, 200, "tag_seq");
        n_checks++; if (tag_err !== 1'b1) $display("FAIL tag_seq_tag_err: got %b want 1", tag_err); else n_pass++;
        n_checks++; if (err_cnt !== 16'd1) $display("FAIL tag_seq_err_cnt: got %0d want 1", err_cnt); else n_pass++;
        n_checks++; if (data_err !== 1'b0) $display("FAIL tag_seq_data_err: got %b want 0", data_err); else n_pass++;
        n_checks++; if (last_tag !== 20'd5) $display("FAIL tag_seq_last_tag: got %0d want 5", last_tag); else n_pass++;
    endtask

    task automatic test_alternating();
        int base;
        do_reset();
        pattern_type = 1'b1;
        push(hdr(7, 1));
        push(32'h5555_5555); push(32'hAAAA_AAAA); push(32'hAAAA_AAAA); push(32'h5555_5555);
        // Phase carries over: the next event must start on 0xAAAAAAAA.
        push(hdr(8, 1));
        push(32'hAAAA_AAAA); push(32'h5555_5555); push(32'hAAAA_AAAA); push(32'h5555_5555);
        base = done_cnt;
        check_enable = 1'b1;
        wait_events(base + 2, 200, "alternating");
        n_checks++; if (data_err !== 1'b1) $display("FAIL alt_data_err: got %b want 1", data_err); else n_pass++;
        n_checks++; if (err_cnt !== 16'd1) $display("FAIL alt_err_cnt: got %0d want 1", err_cnt); else n_pass++;
        n_checks++; if (tag_err !== 1'b0) $display("FAIL alt_tag_err: got %b want 0", tag_err); else n_pass++;
        n_checks++; if (event_cnt !== 16'd2) $display("FAIL alt_event_cnt: got %0d want 2", event_cnt); else n_pass++;
    endtask

    task automatic test_err_clear();
        int base;
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        n_checks++; if (err_cnt !== 16'd0) $display("FAIL clear_err_cnt: got %0d want 0", err_cnt); else n_pass++;
        n_checks++; if ({tag_err, data_err} !== 2'b00) $display("FAIL clear_flags: got %b want 00", {tag_err, data_err}); else n_pass++;
        n_checks++; if (event_cnt !== 16'd0) $display("FAIL clear_event_cnt: got %0d want 0", event_cnt); else n_pass++;
        push(hdr(77, 0));
        base = done_cnt;
        wait_events(base + 1, 100, "clear_first_hdr");
        n_checks++; if (tag_err !== 1'b0) $display("FAIL clear_first_hdr_tag_err: got %b want 0", tag_err); else n_pass++;
        n_checks++; if (last_tag !== 20'd77) $display("FAIL clear_last_tag: got %0d want 77", last_tag); else n_pass++;
    endtask

    task automatic test_stall();
        int base;
        int bad;
        int rd_before;
        do_reset();
        pattern_type = 1'b0;
        push(hdr(9, 2));
        for (int i = 0; i < 4; i++) push(i);
        base = done_cnt;
        check_enable = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (rd_ptr == wr_ptr) break;
            step();
        end
        // Dropping enable while starved must not abort the event.
        check_enable = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (ifc.fifo_re !== 1'b0 || event_done !== 1'b0) bad++;
        end
        n_checks++; if (bad !== 0) $display("FAIL stall_hold: bad cycles %0d want 0", bad); else n_pass++;
        n_checks++; if (done_cnt !== base) $display("FAIL stall_no_done: events %0d want %0d", done_cnt, base); else n_pass++;
        for (int i = 4; i < 8; i++) push(i);
        wait_events(base + 1, 100, "stall_resume");
        n_checks++; if (err_cnt !== 16'd0) $display("FAIL stall_err_cnt: got %0d want 0", err_cnt); else n_pass++;
        n_checks++; if (event_cnt !== 16'd1) $display("FAIL stall_event_cnt: got %0d want 1", event_cnt); else n_pass++;
        push(hdr(10, 0));
        rd_before = rd_ptr;
        repeat (5) step();
        n_checks++; if (rd_ptr !== rd_before) $display("FAIL disabled_idle_reads: got %0d want %0d", rd_ptr, rd_before); else n_pass++;
    endtask

    task automatic test_mid_reset();
        int base;
        int k;
        do_reset();
        pattern_type = 1'b0;
        push(hdr(10, 1));
        push(32'd100); push(32'd101); push(32'd102); push(32'd103);
        check_enable = 1'b1;
        for (k = 0; k < 100; k++) begin
            if (err_cnt == 16'd1) break;
            step();
        end
        n_checks++; if (err_cnt !== 16'd1) $display("FAIL midreset_pending_err: got %0d want 1", err_cnt); else n_pass++;
        step();
        fifoclk_reset = 1'b1;
        flush = 1'b1;
        step();
        step();
        fifoclk_reset = 1'b0;
        flush = 1'b0;
        n_checks++; if ({event_cnt, err_cnt} !== 32'd0) $display("FAIL midreset_counts: got %0d/%0d want 0/0", event_cnt, err_cnt); else n_pass++;
        n_checks++; if ({tag_err, data_err, event_done, ifc.fifo_re} !== 4'b0000) $display("FAIL midreset_flags: got %b want 0000", {tag_err, data_err, event_done, ifc.fifo_re}); else n_pass++;
        n_checks++; if (last_tag !== 20'd0) $display("FAIL midreset_last_tag: got %0d want 0", last_tag); else n_pass++;
        push(hdr(50, 1));
        for (int i = 0; i < 4; i++) push(i);
        base = done_cnt;
        wait_events(base + 1, 100, "midreset_next");
        n_checks++; if ({tag_err, data_err} !== 2'b00) $display("FAIL midreset_next_flags: got %b want 00", {tag_err, data_err}); else n_pass++;
        n_checks++; if (err_cnt !== 16'd0) $display("FAIL midreset_next_err_cnt: got %0d want 0", err_cnt); else n_pass++;
        n_checks++; if (last_tag !== 20'd50) $display("FAIL midreset_next_last_tag: got %0d want 50", last_tag); else n_pass++;
    endtask

    task automatic test_re_rule();
        n_checks++; if (re_viol !== 0) $display("FAIL re_while_empty: got %0d want 0", re_viol); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_counter();
        test_size_zero();
        test_tag_seq();
        test_alternating();
        test_err_clear();
        test_stall();
        test_mid_reset();
        test_re_rule();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
